// File: rtl/safety_interlock.sv
// Laser enable interlock: gates driver ready on pulse-checker fail flags,
// latches fault cause/count, and sequences a timed clear and re-arm holdoff.
module safety_interlock #(
    parameter int CLEAR_WIDTH    = 16,
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable_req,
    input  logic        clear_req,
    input  logic        laser_ready_in,
    input  logic        pulse_lower_limit_fail,
    input  logic        pulse_upper_limit_fail,
    input  logic        rate_lower_limit_fail,
    output logic        laser_ready,
    output logic        clear_fail,
    output logic        fault_latched,
    output logic [2:0]  fault_code,
    output logic [15:0] fault_count,
    output logic [2:0]  state_o
);

    localparam int MAX_CYC = (CLEAR_WIDTH > HOLDOFF_CYCLES) ? CLEAR_WIDTH : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CLEAR_LOAD   = CNT_W'(CLEAR_WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ARMED    = 3'd1,
        FAULT    = 3'd2,
        CLEARING = 3'd3,
        HOLDOFF  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        fault_code_reg, fault_code_next;
    logic [15:0]       fault_count_reg, fault_count_next;
    logic              clear_fail_reg;
    logic              fail_any;
    logic              enter_fault;
    logic              cnt_zero;

    // All fail sources share clk, so they are used unsynchronized for zero-latency cutoff.
    assign fail_any = pulse_lower_limit_fail | pulse_upper_limit_fail | rate_lower_limit_fail;
    assign cnt_zero = (cnt_reg == '0);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        enter_fault = 1'b0;
        case (state_reg)
            DISABLED: begin
                if (fail_any) begin
                    state_next  = FAULT;
                    enter_fault = 1'b1;
                end else if (enable_req) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (fail_any) begin
                    state_next  = FAULT;
                    enter_fault = 1'b1;
                end else if (!enable_req) begin
                    state_next = DISABLED;
                end
            end
            FAULT: begin
                if (clear_req) begin
                    state_next = CLEARING;
                    cnt_next   = CLEAR_LOAD;
                end
            end
            CLEARING: begin
                // A failed clear drops back to FAULT without counting a new fault.
                if (cnt_zero) begin
                    if (fail_any) begin
                        state_next = FAULT;
                    end else begin
                        state_next = HOLDOFF;
                        cnt_next   = HOLDOFF_LOAD;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (fail_any) begin
                    state_next  = FAULT;
                    enter_fault = 1'b1;
                end else if (cnt_zero) begin
                    state_next = enable_req ? ARMED : DISABLED;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next  = FAULT;
                enter_fault = 1'b1;
            end
        endcase

        fault_code_next  = fault_code_reg;
        fault_count_next = fault_count_reg;
        if (enter_fault) begin
            fault_code_next = {rate_lower_limit_fail, pulse_upper_limit_fail, pulse_lower_limit_fail};
            if (fault_count_reg != 16'hFFFF) begin
                fault_count_next = fault_count_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= DISABLED;
            cnt_reg         <= '0;
            fault_code_reg  <= 3'b000;
            fault_count_reg <= 16'd0;
            clear_fail_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            fault_code_reg  <= fault_code_next;
            fault_count_reg <= fault_count_next;
            clear_fail_reg  <= (state_next == CLEARING);
        end
    end

    assign laser_ready   = (state_reg == ARMED) & laser_ready_in & ~fail_any;
    assign clear_fail    = clear_fail_reg;
    assign fault_latched = (state_reg == FAULT) | (state_reg == CLEARING);
    assign fault_code    = fault_code_reg;
    assign fault_count   = fault_count_reg;
    assign state_o       = state_reg;

endmodule

// File: tb/tb_safety_interlock.sv
// Directed bench for safety_interlock: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_safety_interlock;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable_req;
    logic        clear_req;
    logic        laser_ready_in;
    logic        pulse_lower_limit_fail;
    logic        pulse_upper_limit_fail;
    logic        rate_lower_limit_fail;
    logic        laser_ready;
    logic        clear_fail;
    logic        fault_latched;
    logic [2:0]  fault_code;
    logic [15:0] fault_count;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    safety_interlock dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .enable_req             (enable_req),
        .clear_req              (clear_req),
        .laser_ready_in         (laser_ready_in),
        .pulse_lower_limit_fail (pulse_lower_limit_fail),
        .pulse_upper_limit_fail (pulse_upper_limit_fail),
        .rate_lower_limit_fail  (rate_lower_limit_fail),
        .laser_ready            (laser_ready),
        .clear_fail             (clear_fail),
        .fault_latched          (fault_latched),
        .fault_code             (fault_code),
        .fault_count            (fault_count),
        .state_o                (state_o)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        lr;
        logic        cf;
        logic        fl;
        logic [2:0]  code;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    exp_t        e_mon;
    string       n_mon;
    logic [24:0] got_mon;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e_mon   = exp_q.pop_front();
            n_mon   = name_q.pop_front();
            got_mon = {state_o, laser_ready, clear_fail, fault_latched, fault_code, fault_count};
            total++;
            if (got_mon !== e_mon) begin
                bad++;
                $display("FAIL %s: got st=%0d lr=%b cf=%b fl=%b code=%b cnt=%h, required st=%0d lr=%b cf=%b fl=%b code=%b cnt=%h",
                         n_mon, state_o, laser_ready, clear_fail, fault_latched, fault_code, fault_count,
                         e_mon.st, e_mon.lr, e_mon.cf, e_mon.fl, e_mon.code, e_mon.cnt);
            end else begin
                $display("ok   %s: st=%0d lr=%b cf=%b fl=%b code=%b cnt=%h",
                         n_mon, state_o, laser_ready, clear_fail, fault_latched, fault_code, fault_count);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [2:0] st, input logic lr, input logic cf,
                              input logic fl, input logic [2:0] code, input logic [15:0] cnt);
        exp_t e;
        e = '{st: st, lr: lr, cf: cf, fl: fl, code: code, cnt: cnt};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 16 CLEARING cycles; a clear_req pulse mid-way must be ignored.
    task automatic clearing_run(input string nm, input logic [2:0] code, input logic [15:0] cnt);
        for (int i = 0; i < 16; i++) begin
            expect_out(nm, 3'd3, 1'b0, 1'b1, 1'b1, code, cnt);
            clear_req = (i == 5);
            tick();
        end
        clear_req = 1'b0;
    endtask

    task automatic holdoff_run(input string nm, input logic [2:0] code, input logic [15:0] cnt);
        for (int i = 0; i < 1024; i++) begin
            expect_out(nm, 3'd4, 1'b0, 1'b0, 1'b0, code, cnt);
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn                   = 1'b0;
        enable_req             = 1'b0;
        clear_req              = 1'b0;
        laser_ready_in         = 1'b1;
        pulse_lower_limit_fail = 1'b0;
        pulse_upper_limit_fail = 1'b0;
        rate_lower_limit_fail  = 1'b0;

        repeat (2) tick();
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        rstn = 1'b1;
        expect_out("idle", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();

        // Arm and ready gating
        enable_req = 1'b1;
        expect_out("arm_pre", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        expect_out("arm", 3'd1, 1'b1, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        laser_ready_in = 1'b0;
        expect_out("ready_in_low", 3'd1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        laser_ready_in = 1'b1;
        expect_out("ready_in_high", 3'd1, 1'b1, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();

        // Zero-latency cutoff and fault capture
        pulse_upper_limit_fail = 1'b1;
        expect_out("cutoff", 3'd1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        pulse_upper_limit_fail = 1'b0;
        expect_out("fault_entry", 3'd2, 1'b0, 1'b0, 1'b1, 3'b010, 16'd1);
        tick();
        expect_out("fault_ignores_enable", 3'd2, 1'b0, 1'b0, 1'b1, 3'b010, 16'd1);
        clear_req = 1'b1;
        tick();

        // Successful clear, full holdoff, re-arm
        clearing_run("clear_ok", 3'b010, 16'd1);
        holdoff_run("holdoff", 3'b010, 16'd1);
        expect_out("rearm", 3'd1, 1'b1, 1'b0, 1'b0, 3'b010, 16'd1);
        tick();

        // Clear blocked by persistent rate fail
        rate_lower_limit_fail = 1'b1;
        expect_out("rate_cutoff", 3'd1, 1'b0, 1'b0, 1'b0, 3'b010, 16'd1);
        tick();
        expect_out("rate_fault", 3'd2, 1'b0, 1'b0, 1'b1, 3'b100, 16'd2);
        clear_req = 1'b1;
        tick();
        clearing_run("clear_blocked", 3'b100, 16'd2);
        expect_out("blocked_back", 3'd2, 1'b0, 1'b0, 1'b1, 3'b100, 16'd2);
        rate_lower_limit_fail = 1'b0;
        tick();
        expect_out("fault_idle", 3'd2, 1'b0, 1'b0, 1'b1, 3'b100, 16'd2);
        clear_req = 1'b1;
        tick();

        // Simultaneous fails during holdoff
        clearing_run("clear2", 3'b100, 16'd2);
        expect_out("holdoff_entry", 3'd4, 1'b0, 1'b0, 1'b0, 3'b100, 16'd2);
        tick();
        pulse_lower_limit_fail = 1'b1;
        rate_lower_limit_fail  = 1'b1;
        expect_out("holdoff_fail", 3'd4, 1'b0, 1'b0, 1'b0, 3'b100, 16'd2);
        tick();
        pulse_lower_limit_fail = 1'b0;
        rate_lower_limit_fail  = 1'b0;
        expect_out("simul_fault", 3'd2, 1'b0, 1'b0, 1'b1, 3'b101, 16'd3);
        tick();

        // Saturation: preload the counter just below the ceiling
        force dut.fault_count_reg = 16'hFFFE;
        tick();
        release dut.fault_count_reg;
        expect_out("preset", 3'd2, 1'b0, 1'b0, 1'b1, 3'b101, 16'hFFFE);
        clear_req = 1'b1;
        tick();
        clearing_run("clear3", 3'b101, 16'hFFFE);
        expect_out("holdoff2", 3'd4, 1'b0, 1'b0, 1'b0, 3'b101, 16'hFFFE);
        pulse_lower_limit_fail = 1'b1;
        tick();
        pulse_lower_limit_fail = 1'b0;
        expect_out("sat_last", 3'd2, 1'b0, 1'b0, 1'b1, 3'b001, 16'hFFFF);
        clear_req = 1'b1;
        tick();
        clearing_run("clear4", 3'b001, 16'hFFFF);
        expect_out("holdoff3", 3'd4, 1'b0, 1'b0, 1'b0, 3'b001, 16'hFFFF);
        pulse_upper_limit_fail = 1'b1;
        tick();
        pulse_upper_limit_fail = 1'b0;
        expect_out("sat_hold", 3'd2, 1'b0, 1'b0, 1'b1, 3'b010, 16'hFFFF);
        clear_req = 1'b1;
        tick();

        // Reset mid-holdoff, then immediate re-arm
        clearing_run("clear5", 3'b010, 16'hFFFF);
        expect_out("holdoff4", 3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 16'hFFFF);
        tick();
        expect_out("holdoff5", 3'd4, 1'b0, 1'b0, 1'b0, 3'b010, 16'hFFFF);
        tick();
        rstn = 1'b0;
        expect_out("reset_mid", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        expect_out("reset_hold", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        rstn = 1'b1;
        tick();
        expect_out("rearm_after_reset", 3'd1, 1'b1, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();

        // Disarm, then fault from DISABLED
        enable_req = 1'b0;
        expect_out("disarm_pre", 3'd1, 1'b1, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        clear_req = 1'b1;
        expect_out("disarmed", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        clear_req = 1'b0;
        pulse_lower_limit_fail = 1'b1;
        expect_out("dis_fail", 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0);
        tick();
        pulse_lower_limit_fail = 1'b0;
        expect_out("dis_fault", 3'd2, 1'b0, 1'b0, 1'b1, 3'b001, 16'd1);
        tick();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/safety_interlock.md
SAFETY_INTERLOCK -- requirements
Module: safety_interlock

Interface
REQ-001 SHALL have parameter CLEAR_WIDTH, default 16: clear_fail pulse length in clk cycles, at least 8 so the divided-clock checker samples it.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 1024: re-arm holdoff length in clk cycles after a successful clear.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port enable_req, input, 1: host level request to arm the laser path.
REQ-006 SHALL have port clear_req, input, 1: host single-cycle fault-clear request.
REQ-007 SHALL have port laser_ready_in, input, 1: driver-side ready level.
REQ-008 SHALL have port pulse_lower_limit_fail, input, 1: pulse-checker fail flag.
REQ-009 SHALL have port pulse_upper_limit_fail, input, 1: pulse-checker fail flag.
REQ-010 SHALL have port rate_lower_limit_fail, input, 1: pulse-checker fail flag.
REQ-011 SHALL have port laser_ready, output, 1: gated ready, fed to the pulse checker and the laser driver.
REQ-012 SHALL have port clear_fail, output, 1: clear strobe to the pulse checker.
REQ-013 SHALL have port fault_latched, output, 1: high while in FAULT or CLEARING.
REQ-014 SHALL have port fault_code, output, 3: {rate, upper, lower} snapshot of the fail inputs at the last FAULT entry.
REQ-015 SHALL have port fault_count, output, 16: count of FAULT entries, saturating.
REQ-016 SHALL have port state_o, output, 3: current state encoding.

Function
REQ-017 SHALL define fail_any as the OR of the three fail inputs, sampled directly with no added synchronizer, since all sources run on the clk domain.
REQ-018 SHALL implement the states DISABLED=0, ARMED=1, FAULT=2, CLEARING=3, HOLDOFF=4; encodings 5-7 SHALL go to FAULT on the next edge.
REQ-019 SHALL make laser_ready combinational: (state==ARMED) & laser_ready_in & ~fail_any, so cutoff has zero cycles of latency from fail_any.
REQ-020 In DISABLED, SHALL go to FAULT if fail_any=1, else go to ARMED if enable_req=1, else stay.
REQ-021 In ARMED, SHALL go to FAULT if fail_any=1 (this has priority), else go to DISABLED if enable_req=0.
REQ-022 On every transition into FAULT, SHALL load fault_code with {rate_lower_limit_fail, pulse_upper_limit_fail, pulse_lower_limit_fail} from that edge, and SHALL increment fault_count, saturating at 16'hFFFF.
REQ-023 In FAULT, SHALL go to CLEARING when clear_req=1 and ignore enable_req.
REQ-024 In CLEARING, SHALL drive clear_fail=1 for exactly CLEAR_WIDTH cycles, then on the following edge go to HOLDOFF if fail_any=0, else return to FAULT.
REQ-025 A return from CLEARING to FAULT SHALL leave fault_count and fault_code unchanged.
REQ-026 SHALL drive clear_fail=0 in all states other than CLEARING.
REQ-027 SHALL ignore clear_req in every state except FAULT, including while in CLEARING.
REQ-028 In HOLDOFF, SHALL count HOLDOFF_CYCLES cycles; fail_any=1 at any point SHALL go to FAULT, with capture and increment per REQ-022.
REQ-029 At HOLDOFF expiry, SHALL go to ARMED if enable_req=1, else to DISABLED.
REQ-030 SHALL retain fault_code until the next FAULT entry; it SHALL NOT be cleared by a successful clear.
REQ-031 SHALL use one shared down-counter for CLEARING and HOLDOFF, reloaded on each entry to either state, and sized for max(CLEAR_WIDTH, HOLDOFF_CYCLES).
REQ-032 SHALL drive state_o registered, equal to the current state.

Reset
REQ-033 On rstn=0, SHALL asynchronously force state DISABLED, clear_fail=0, fault_code=0, fault_count=0 and counter=0, and hence laser_ready=0 and fault_latched=0.
REQ-034 On reset assertion mid-CLEARING or mid-HOLDOFF, SHALL abort immediately; after release the block SHALL start in DISABLED.
REQ-035 SHALL resume on the first clk edge after rstn deasserts.

Verification
REQ-036 Arm: enable_req=1, laser_ready_in=1, no fails -> state_o=1 after 1 edge; laser_ready=1.
REQ-037 Fault cutoff: in ARMED, pulse_upper_limit_fail=1 -> laser_ready=0 in the same cycle; next edge state_o=2, fault_code=3'b010, fault_count=1.
REQ-038 Clear OK: fails low, clear_req pulse -> clear_fail high for exactly 16 cycles; then state_o=4 for 1024 cycles; then state_o=1 with enable_req=1.
REQ-039 Clear blocked: rate_lower_limit_fail held high through CLEARING -> state_o returns to 2; fault_count unchanged; fault_code=3'b100.
REQ-040 Simultaneous and saturate: lower and rate fails asserted together -> fault_code=3'b101; with fault_count preset via 65535 repeated faults, one more fault -> stays 16'hFFFF.
REQ-041 Reset mid-HOLDOFF: rstn pulse low -> all outputs 0, state_o=0; re-arm succeeds with no holdoff.
